// File: rtl/wide_mult_axi_legup_mult_pkg.sv
// Shared types and elaboration helpers for the iterative wide multiplier.
// Widths are passed as arguments so one package serves every parameterisation.
package wide_mult_axi_legup_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper bound on operand width handled by the magnitude helper.
    localparam int MAXW = 256;

    function automatic int nchunk_f(input int wb, input int ch);
        return (ch < 1) ? 1 : wb / ch;
    endfunction

    function automatic int cnt_width_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit cfg_ok_f(input int wb, input int ch);
        if (ch < 1) begin
            return 1'b0;
        end
        return (wb % ch) == 0;
    endfunction

    // |v| over the low w bits; the most-negative value maps to 2^(w-1), which still fits.
    function automatic logic [MAXW-1:0] magnitude_f(input logic [MAXW-1:0] v, input int w,
                                                    input logic sgn);
        logic [MAXW-1:0] mask;
        logic            msb;
        mask = {MAXW{1'b1}} >> (MAXW - w);
        msb  = |(v & (MAXW'(1) << (w - 1)));
        if (sgn && msb) begin
            return (~v + MAXW'(1)) & mask;
        end
        return v & mask;
    endfunction

    function automatic logic negate_f(input logic sgn, input logic a_msb, input logic b_msb);
        return sgn & (a_msb ^ b_msb);
    endfunction

endpackage

// File: rtl/wide_mult_axi_legup_mult_iter_if.sv
// Operand/result handshake bundle for the iterative wide multiplier.
// master = producer/consumer side, slave = the multiplier.
interface wide_mult_axi_legup_mult_iter_if #(
    parameter int widtha = 32,
    parameter int widthb = 32,
    parameter int widthp = 64
);
    logic              in_valid;
    logic              in_ready;
    logic              in_signed;
    logic [widtha-1:0] dataa;
    logic [widthb-1:0] datab;
    logic              out_valid;
    logic              out_ready;
    logic [widthp-1:0] result;

    modport master (
        output in_valid, in_signed, dataa, datab, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in_signed, dataa, datab, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/wide_mult_axi_legup_mult_chunk.sv
// Unsigned widtha x chunk partial-product multiplier, purely combinational.
// One instance is time-shared across all chunks of operand b.
module wide_mult_axi_legup_mult_chunk #(
    parameter int widtha = 32,
    parameter int chunk  = 8
) (
    input  logic [widtha-1:0]       a,
    input  logic [chunk-1:0]        b,
    output logic [widtha+chunk-1:0] p
);
    localparam int PPW = widtha + chunk;

    assign p = PPW'(a) * PPW'(b);
endmodule

// File: rtl/wide_mult_axi_legup_mult_iter.sv
// Iterative signed/unsigned wide multiplier: one chunk of |b| per cycle into a
// full-width accumulator, sign applied only when the product is presented.
module wide_mult_axi_legup_mult_iter
    import wide_mult_axi_legup_mult_pkg::*;
#(
    parameter int widtha = 32,
    parameter int widthb = 32,
    parameter int widthp = 64,
    parameter int chunk  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    wide_mult_axi_legup_mult_iter_if.slave bus
);
    localparam int NCHUNK = nchunk_f(widthb, chunk);
    localparam int CW     = cnt_width_f(NCHUNK);
    localparam int PW     = widtha + widthb;
    localparam int SHW    = $clog2(PW) + 1;

    generate
        if (!cfg_ok_f(widthb, chunk)) begin : g_cfg_err
            $error("widthb must be a positive multiple of chunk");
        end
    endgenerate

    state_t              state_reg;
    logic [CW-1:0]       k_reg;
    logic [PW-1:0]       acc_reg;
    logic [widtha-1:0]   mag_a_reg;
    logic [widthb-1:0]   mag_b_reg;
    logic                neg_reg;
    logic                sgn_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;

    logic [widtha-1:0]       mag_a_next;
    logic [widthb-1:0]       mag_b_next;
    logic                    neg_next;
    logic [widtha+chunk-1:0] pp;
    logic [SHW-1:0]          shamt;
    logic [PW-1:0]           acc_next;
    logic                    k_last;
    logic [PW-1:0]           prod;
    logic [widthp-1:0]       result_w;

    assign mag_a_next = widtha'(magnitude_f(MAXW'(bus.dataa), widtha, bus.in_signed));
    assign mag_b_next = widthb'(magnitude_f(MAXW'(bus.datab), widthb, bus.in_signed));
    assign neg_next   = negate_f(bus.in_signed, bus.dataa[widtha-1], bus.datab[widthb-1]);

    // |b| is shifted down each step, so the active chunk is always the low bits.
    wide_mult_axi_legup_mult_chunk #(
        .widtha (widtha),
        .chunk  (chunk)
    ) u_chunk (
        .a (mag_a_reg),
        .b (mag_b_reg[chunk-1:0]),
        .p (pp)
    );

    assign shamt    = SHW'(k_reg) * SHW'(chunk);
    assign acc_next = acc_reg + (PW'(pp) << shamt);
    assign k_last   = (k_reg == CW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            acc_reg       <= '0;
            mag_a_reg     <= '0;
            mag_b_reg     <= '0;
            neg_reg       <= 1'b0;
            sgn_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_a_reg    <= mag_a_next;
                        mag_b_reg    <= mag_b_next;
                        neg_reg      <= neg_next;
                        sgn_reg      <= bus.in_signed;
                        acc_reg      <= '0;
                        k_reg        <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= MUL;
                    end
                end
                MUL: begin
                    acc_reg   <= acc_next;
                    mag_b_reg <= mag_b_reg >> chunk;
                    k_reg     <= k_reg + CW'(1);
                    if (k_last) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign prod = neg_reg ? (~acc_reg + PW'(1)) : acc_reg;

    // Bits above the natural product width carry the sign only in signed mode.
    genvar gi;
    generate
        for (gi = 0; gi < widthp; gi++) begin : g_res
            if (gi < PW) begin : g_body
                assign result_w[gi] = prod[gi];
            end else begin : g_ext
                assign result_w[gi] = sgn_reg & prod[PW-1];
            end
        end
    endgenerate

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_w;
endmodule

// File: tb/tb_wide_mult_axi_legup_mult_iter.sv
// Bench for the iterative wide multiplier: arithmetic/timing model checked every
// cycle, directed literal cases, random traffic, and a narrow variant instance.
module tb_wide_mult_axi_legup_mult_iter;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wide_mult_axi_legup_mult_iter_if #(.widtha(32), .widthb(32), .widthp(64)) bus ();
    wide_mult_axi_legup_mult_iter_if #(.widtha(32), .widthb(32), .widthp(32)) bus2 ();

    wide_mult_axi_legup_mult_iter #(
        .widtha(32), .widthb(32), .widthp(64), .chunk(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    wide_mult_axi_legup_mult_iter #(
        .widtha(32), .widthb(32), .widthp(32), .chunk(16)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, required 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting on DUT (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        return s ? 64'(sa * sb) : 64'(ua * ub);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference: busy from accept until the output handshake, result valid NCH+1 cycles after accept.
    bit          m_busy = 1'b0;
    int          m_acc_cyc = 0;
    logic [63:0] m_exp = '0;
    bit          m_ev;
    int          n_txn = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            m_ev = m_busy && (cyc >= m_acc_cyc + NCH + 1);
            check("in_ready", 64'(bus.in_ready), 64'(!m_busy));
            check("out_valid", 64'(bus.out_valid), 64'(m_ev));
            if (m_ev) check("result", bus.result, m_exp);
            if (reset) begin
                m_busy = 1'b0;
            end else if (m_ev && bus.out_ready) begin
                m_busy = 1'b0;
                $display("txn %0d: done cycle %0d result 0x%h", n_txn, cyc, bus.result);
                n_txn++;
            end else if (!m_busy && bus.in_valid) begin
                m_busy    = 1'b1;
                m_acc_cyc = cyc;
                m_exp     = golden(bus.dataa, bus.datab, bus.in_signed);
                $display("txn %0d: accept cycle %0d a=0x%h b=0x%h signed=%0d expect 0x%h",
                         n_txn, cyc, bus.dataa, bus.datab, bus.in_signed, m_exp);
            end
        end
    end

    // One operation with a literal expectation; returns at the negedge where out_valid is high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] lit, input string nm);
        int n;
        bit seen;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.dataa = a;
        bus.datab = b;
        bus.in_signed = s;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.in_ready;
        end
        if (!seen) begin
            timeout_fail({nm, " accept"});
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dataa = $urandom;
        bus.datab = $urandom;
        bus.in_signed = ~s;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            seen = bus.out_valid;
        end
        if (!seen) begin
            timeout_fail({nm, " out_valid"});
            return;
        end
        check({nm, " latency"}, 64'(n), 64'(NCH + 1));
        check({nm, " result"}, bus.result, lit);
    endtask

    logic [31:0] v_a [2] = '{32'h0001_0000, 32'hFFFF_FFFE};
    logic [31:0] v_b [2] = '{32'h0001_0000, 32'h0000_0003};
    logic        v_s [2] = '{1'b0, 1'b1};
    logic [31:0] v_r [2] = '{32'h0000_0000, 32'hFFFF_FFFA};

    initial begin
        logic [63:0] held;
        bit seen;
        int last_acc;
        int n;

        bus.in_valid = 1'b0;
        bus.in_signed = 1'b0;
        bus.dataa = '0;
        bus.datab = '0;
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0;
        bus2.in_signed = 1'b0;
        bus2.dataa = '0;
        bus2.datab = '0;
        bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset result", bus.result, 64'd0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "neg3x5");

        // Backpressure: hold DONE for 10 cycles, then release and re-accept immediately.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        run_op(32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_EDCC, "bp");
        held = bus.result;
        repeat (10) begin
            @(negedge clk);
            check("bp stable", bus.result, held);
            check("bp in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.dataa = 32'hFFFF_FFFF;
        bus.datab = 32'hFFFF_FFFF;
        bus.in_signed = 1'b1;
        @(negedge clk);
        check("bp release in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("bp reaccept in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        if (!seen) timeout_fail("m1xm1 out_valid");
        else check("m1xm1 result", bus.result, 64'h1);

        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "minxmin");

        // Reset during the second MUL cycle discards the operation.
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.dataa = 32'd1234;
        bus.datab = 32'd5678;
        bus.in_signed = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.in_ready;
        end
        if (!seen) timeout_fail("rst accept");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst in_ready", 64'(bus.in_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            check("rst no out_valid", 64'(bus.out_valid), 64'd0);
        end
        run_op(32'd7, 32'd9, 1'b0, 64'h3F, "after_rst");

        // Back-to-back stream with in_valid held high.
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.dataa = pick_operand();
        bus.datab = pick_operand();
        bus.in_signed = 1'($urandom_range(0, 1));
        last_acc = 0;
        for (int i = 0; i < 8; i++) begin
            seen = 1'b0;
            for (int j = 0; j < 20 && !seen; j++) begin
                @(negedge clk);
                seen = bus.in_ready;
            end
            if (!seen) begin
                timeout_fail("b2b accept");
                break;
            end
            if (i > 0) check("b2b spacing", 64'(cyc - last_acc), 64'd6);
            last_acc = cyc;
            @(posedge clk);
            #1;
            bus.dataa = pick_operand();
            bus.datab = pick_operand();
            bus.in_signed = 1'($urandom_range(0, 1));
        end
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);

        // Random valid/ready traffic against the model.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.dataa = pick_operand();
            bus.datab = pick_operand();
            bus.in_signed = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Narrow variant: widthp=32, chunk=16, latency 3.
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            #1;
            bus2.in_valid = 1'b1;
            bus2.dataa = v_a[t];
            bus2.datab = v_b[t];
            bus2.in_signed = v_s[t];
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = bus2.in_ready;
            end
            if (!seen) begin
                timeout_fail("variant accept");
                continue;
            end
            @(posedge clk);
            #1;
            bus2.in_valid = 1'b0;
            n = 0;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                n++;
                seen = bus2.out_valid;
            end
            if (!seen) begin
                timeout_fail("variant out_valid");
                continue;
            end
            check("variant latency", 64'(n), 64'd3);
            check("variant result", 64'(bus2.result), 64'(v_r[t]));
            $display("variant txn %0d: result 0x%h latency %0d", t, bus2.result, n);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
